rr_sched3: RTL

- Round-robin scheduler that shares one FSM-driven resource between three requesters (i0/i1/i2-style request lines).
- Issues a one-hot grant plus a 2-bit encoded owner id, sized to match the fsm state/output width, so the id can feed the fsm `a`/`y` path directly.
- Enforces a bounded hold time and a one-cycle dead gap between owners.
- Sits between the request sources and the fsm datapath, in the same single clock domain.

---
 rtl/rr_sched3.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/rr_sched3.sv
// Round-robin scheduler: three level-sensitive requesters share one resource, with a bounded hold
// and a one-cycle dead gap between owners. Grant visible 1 cycle after arbitration.
module rr_sched3 #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic       done,
    output logic [2:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam int              HOLD_EFF = (HOLD_MAX < 1) ? 1 : HOLD_MAX;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_EFF - 1);

    logic [1:0]       state_q, state_d;
    logic [2:0]       gnt_q, gnt_d;
    logic [1:0]       gnt_id_q, gnt_id_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    logic [1:0] cand0, cand1, cand2;
    logic [1:0] win_id;
    logic       win_vld;
    logic       owner_req;
    logic       expire;

    // Search order starts just after the previous owner, which therefore ranks last.
    always_comb begin
        cand0 = 2'd0;
        cand1 = 2'd1;
        cand2 = 2'd2;
        case (last_q)
            2'd0: begin
                cand0 = 2'd1;
                cand1 = 2'd2;
                cand2 = 2'd0;
            end
            2'd1: begin
                cand0 = 2'd2;
                cand1 = 2'd0;
                cand2 = 2'd1;
            end
            default: begin
                cand0 = 2'd0;
                cand1 = 2'd1;
                cand2 = 2'd2;
            end
        endcase

        win_vld = |req;
        if (req[cand0]) begin
            win_id = cand0;
        end else if (req[cand1]) begin
            win_id = cand1;
        end else begin
            win_id = cand2;
        end
    end

    assign owner_req = |(req & gnt_q);
    assign expire    = (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;

        case (state_q)
            S_IDLE, S_GAP: begin
                cnt_d = '0;
                if (win_vld) begin
                    state_d  = S_GRANT;
                    gnt_d    = 3'(3'b001 << win_id);
                    gnt_id_d = win_id;
                    last_d   = win_id;
                end else begin
                    state_d  = S_IDLE;
                    gnt_d    = 3'b000;
                    gnt_id_d = 2'd3;
                end
            end
            S_GRANT: begin
                if (done || !owner_req || expire) begin
                    state_d   = S_GAP;
                    gnt_d     = 3'b000;
                    gnt_id_d  = 2'd3;
                    cnt_d     = '0;
                    // Only a pure hold expiry counts as a revocation.
                    timeout_d = expire && !done && owner_req;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d  = S_IDLE;
                gnt_d    = 3'b000;
                gnt_id_d = 2'd3;
                cnt_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            gnt_q     <= 3'b000;
            gnt_id_q  <= 2'd3;
            last_q    <= 2'd2;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Outputs are qualified by state so an illegal encoding can never leak a grant.
    assign gnt     = (state_q == S_GRANT) ? gnt_q : 3'b000;
    assign gnt_id  = (state_q == S_GRANT) ? gnt_id_q : 2'd3;
    assign busy    = (state_q == S_GRANT) || (state_q == S_GAP);
    assign timeout = timeout_q && (state_q == S_GAP);

endmodule
